// File: rtl/octal_pkg.sv
// ----------------------------------------------------------------------------
// octal_pkg : shared types and helpers for the octal key front-end. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package octal_pkg;

  localparam int KEY_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // True only for exactly one bit set; all-zero is not one-hot.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce : two-flop synchroniser plus whole-vector debounce. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_debounce #(
  parameter int DB_CNT = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] keys_i,
  output logic [WIDTH-1:0] deb_o
);

  localparam int CNT_W = $clog2(DB_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      samp_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= keys_i;
      s2_q   <= s1_q;
      samp_q <= samp_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any change of the synchronised vector restarts the stability count.
  always_comb begin
    samp_d = samp_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (s2_q != samp_q) begin
      samp_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d  = samp_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  assign deb_o = deb_q;

endmodule

`default_nettype wire

// File: rtl/octal_key_capture.sv
// ----------------------------------------------------------------------------
// octal_key_capture : qualifies one clean key press as a one-hot code. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module octal_key_capture
  import octal_pkg::*;
#(
  parameter int DB_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] keys,
  input  logic             ack,
  output logic [KEY_W-1:0] out,
  output logic             valid,
  output logic             multi
);

  logic [KEY_W-1:0] deb;
  state_t           state_q, state_d;
  logic [KEY_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;

  key_debounce #(
    .DB_CNT (DB_CNT),
    .WIDTH  (KEY_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .keys_i (keys),
    .deb_o  (deb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  // Only IDLE looks at the key vector for new presses, so extra keys
  // during HOLD/WAIT_REL can neither change the code nor raise multi.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    multi_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_onehot(deb)) begin
          state_d = HOLD;
          out_d   = deb;
          valid_d = 1'b1;
        end else if (deb != '0) begin
          state_d = WAIT_REL;
          multi_d = 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          state_d = WAIT_REL;
          out_d   = '0;
          valid_d = 1'b0;
        end
      end
      WAIT_REL: begin
        if (deb == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

`default_nettype wire

// File: tb/tb_octal_key_capture.sv
// ----------------------------------------------------------------------------
// tb_octal_key_capture : directed bench for octal_key_capture (DB_CNT=4). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_octal_key_capture;

  logic       clk;
  logic       rst_n;
  logic [7:0] keys;
  logic       ack;
  logic [7:0] out;
  logic       valid;
  logic       multi;

  int n_checks;
  int n_errors;
  int multi_cnt;
  int inv_err;
  int m0;
  logic mon_en;
  logic saw;

  octal_key_capture #(
    .DB_CNT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .keys  (keys),
    .ack   (ack),
    .out   (out),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running observations: multi pulse count and the one-hot/valid invariant.
  always @(negedge clk) begin
    if (mon_en) begin
      if (multi) multi_cnt++;
      if (($countones(out) > 1) || (valid != (out != 8'h00))) inv_err++;
    end
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_and_release();
    ack = 1'b1;
    tick(1);
    ack  = 1'b0;
    keys = 8'h00;
    tick(12);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    multi_cnt = 0;
    inv_err   = 0;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    keys      = 8'h00;
    ack       = 1'b0;

    tick(3);
    check("rst_out",   out,            8'h00);
    check("rst_valid", {7'd0, valid},  8'h00);
    check("rst_multi", {7'd0, multi},  8'h00);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Clean single press: valid exactly 7 edges after keys is first sampled.
    keys = 8'h08;
    tick(7);
    check("t1_valid_early", {7'd0, valid}, 8'h00);
    tick(1);
    check("t1_valid", {7'd0, valid}, 8'h01);
    check("t1_out",   out,           8'h08);
    tick(10);
    check("t1_valid_held", {7'd0, valid}, 8'h01);
    check("t1_out_held",   out,           8'h08);
    check("t1_no_multi",   8'(multi_cnt), 8'h00);

    // Handshake, hold-down, then release and re-press.
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("t2_ack_valid", {7'd0, valid}, 8'h00);
    check("t2_ack_out",   out,           8'h00);
    keys = 8'h00;
    tick(12);
    keys = 8'h40;
    tick(8);
    check("t2_valid", {7'd0, valid}, 8'h01);
    check("t2_out",   out,           8'h40);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("t2_drop_valid", {7'd0, valid}, 8'h00);
    check("t2_drop_out",   out,           8'h00);
    saw = 1'b0;
    repeat (30) begin
      tick(1);
      saw = saw | valid;
    end
    check("t2_no_second_valid", {7'd0, saw}, 8'h00);
    keys = 8'h00;
    tick(10);
    keys = 8'h40;
    tick(7);
    check("t2_repress_early", {7'd0, valid}, 8'h00);
    tick(1);
    check("t2_repress_valid", {7'd0, valid}, 8'h01);
    check("t2_repress_out",   out,           8'h40);
    ack_and_release();

    // Bounce rejection: 2-cycle levels never reach the debounced vector.
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 8'h01 : 8'h00;
      repeat (2) begin
        tick(1);
        saw = saw | valid;
      end
    end
    check("t3_no_valid_bounce", {7'd0, saw}, 8'h00);
    keys = 8'h01;
    tick(7);
    check("t3_valid_early", {7'd0, valid}, 8'h00);
    tick(1);
    check("t3_valid", {7'd0, valid}, 8'h01);
    check("t3_out",   out,           8'h01);
    ack_and_release();

    // Multi-key: one multi pulse, no valid, partial release stays rejected.
    m0   = multi_cnt;
    keys = 8'h0A;
    tick(7);
    check("t4_multi_early", {7'd0, multi}, 8'h00);
    tick(1);
    check("t4_multi_pulse", {7'd0, multi}, 8'h01);
    check("t4_no_valid",    {7'd0, valid}, 8'h00);
    tick(1);
    check("t4_multi_end",   {7'd0, multi}, 8'h00);
    keys = 8'h02;
    saw  = 1'b0;
    repeat (15) begin
      tick(1);
      saw = saw | valid;
    end
    check("t4_no_valid_partial", {7'd0, saw},       8'h00);
    check("t4_one_multi",        8'(multi_cnt - m0), 8'h01);
    keys = 8'h00;
    tick(12);

    // Ignored inputs: ack in IDLE, extra key during HOLD.
    ack = 1'b1;
    tick(3);
    ack = 1'b0;
    check("t5_idle_ack_valid", {7'd0, valid}, 8'h00);
    check("t5_idle_ack_out",   out,           8'h00);
    keys = 8'h10;
    tick(8);
    check("t5_valid", {7'd0, valid}, 8'h01);
    check("t5_out",   out,           8'h10);
    m0   = multi_cnt;
    keys = 8'h11;
    tick(15);
    check("t5_hold_valid", {7'd0, valid},      8'h01);
    check("t5_hold_out",   out,                8'h10);
    check("t5_no_multi",   8'(multi_cnt - m0), 8'h00);
    ack_and_release();

    // Reset mid-HOLD, then a fresh press with keys still down.
    keys = 8'h80;
    tick(8);
    check("t6_valid", {7'd0, valid}, 8'h01);
    check("t6_out",   out,           8'h80);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_out",   out,           8'h00);
    check("t6_rst_valid", {7'd0, valid}, 8'h00);
    check("t6_rst_multi", {7'd0, multi}, 8'h00);
    rst_n = 1'b1;
    tick(7);
    check("t6_fresh_early", {7'd0, valid}, 8'h00);
    tick(1);
    check("t6_fresh_valid", {7'd0, valid}, 8'h01);
    check("t6_fresh_out",   out,           8'h80);

    check("onehot_invariant", 8'(inv_err), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
